// File: rtl/mac_fp_pkg.sv
// Shared widths, lane constants and sweep FSM states for the 5-input FP MAC
// operand mux and its result collector.
package mac_fp_pkg;

    localparam int unsigned DEF_SIG_WIDTH = 23;
    localparam int unsigned DEF_EXP_WIDTH = 8;
    localparam int unsigned DEF_A_WIDTH   = DEF_SIG_WIDTH + DEF_EXP_WIDTH + 1;

    localparam int unsigned LANES  = 5;
    localparam int unsigned LANE_W = 3;
    localparam int unsigned STAT_W = 8;

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mac_tag_pipe.sv
// Delay line of {valid, lane} tags that follows issued lanes through the MAC
// latency; DEPTH=0 is a combinational pass-through.
module mac_tag_pipe
    import mac_fp_pkg::*;
#(
    parameter int DEPTH = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [LANE_W-1:0] in_lane,
    output logic              out_valid,
    output logic [LANE_W-1:0] out_lane
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_pass;
            assign unused_pass = &{1'b0, clk, rst_n};
            assign out_valid   = in_valid;
            assign out_lane    = in_lane;
        end else begin : g_pipe
            logic [DEPTH-1:0]             v_q;
            logic [DEPTH-1:0][LANE_W-1:0] l_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    v_q <= '0;
                    l_q <= '0;
                end else begin
                    v_q[0] <= in_valid;
                    l_q[0] <= in_lane;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        v_q[i] <= v_q[i-1];
                        l_q[i] <= l_q[i-1];
                    end
                end
            end

            assign out_valid = v_q[DEPTH-1];
            assign out_lane  = l_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/mac_fp_result_collect_5.sv
// Sweeps the MAC operand mux over lanes 0..4, collects each lane's z/status
// after MAC_LAT cycles and presents the packed results with valid/ready.
module mac_fp_result_collect_5
    import mac_fp_pkg::*;
#(
    parameter int SIG_WIDTH = DEF_SIG_WIDTH,
    parameter int EXP_WIDTH = DEF_EXP_WIDTH,
    parameter int A_WIDTH   = SIG_WIDTH + EXP_WIDTH + 1,
    parameter int MAC_LAT   = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_valid,
    output logic                     start_ready,
    output logic [LANE_W-1:0]        mac_select,
    input  logic [A_WIDTH-1:0]       mac_z,
    input  logic [STAT_W-1:0]        mac_status,
    output logic [LANES*A_WIDTH-1:0] res_z,
    output logic [LANES*STAT_W-1:0]  res_status,
    output logic [STAT_W-1:0]        res_status_or,
    output logic                     res_valid,
    input  logic                     res_ready
);

    state_t              state_q;
    state_t              state_d;
    logic [LANE_W-1:0]   sel_d;
    logic                start_fire;
    logic                tag_in_valid;
    logic                tag_out_valid;
    logic [LANE_W-1:0]   tag_out_lane;
    logic                capture;
    logic                last_capture;

    assign tag_in_valid = (state_q == ST_ISSUE);

    mac_tag_pipe #(
        .DEPTH (MAC_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (tag_in_valid),
        .in_lane   (mac_select),
        .out_valid (tag_out_valid),
        .out_lane  (tag_out_lane)
    );

    // Captures are gated by state so a tag can never write into a parked result.
    assign capture      = tag_out_valid && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));
    assign last_capture = capture && (tag_out_lane == LAST_LANE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = mac_select;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        start_fire  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                start_ready = 1'b1;
                sel_d       = '0;
                if (start_valid) begin
                    start_fire = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mac_select == LAST_LANE) begin
                    if (MAC_LAT == 0) begin
                        state_d = ST_DONE;
                        sel_d   = '0;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    sel_d = mac_select + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (last_capture) begin
                    state_d = ST_DONE;
                    sel_d   = '0;
                end
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mac_select    <= '0;
            res_z         <= '0;
            res_status    <= '0;
            res_status_or <= '0;
        end else begin
            mac_select <= sel_d;
            if (start_fire) begin
                res_z         <= '0;
                res_status    <= '0;
                res_status_or <= '0;
            end else if (capture) begin
                for (int unsigned k = 0; k < LANES; k++) begin
                    if (tag_out_lane == LANE_W'(k)) begin
                        res_z[k*A_WIDTH +: A_WIDTH]  <= mac_z;
                        res_status[k*STAT_W +: STAT_W] <= mac_status;
                    end
                end
                res_status_or <= res_status_or | mac_status;
            end
        end
    end

endmodule

// File: tb/tb_mac_fp_result_collect_5.sv
// Directed bench: three collectors with MAC_LAT 0/1/2, each fed by a MAC model
// that returns a per-lane table entry delayed by its latency.
module tb_mac_fp_result_collect_5;

    logic clk;
    logic rst_n;

    logic [2:0]          sv;
    logic [2:0]          rr;
    logic [2:0]          sr;
    logic [2:0]          rv;
    logic [2:0][2:0]     sel;
    logic [2:0][31:0]    mz;
    logic [2:0][7:0]     ms;
    logic [2:0][159:0]   rz;
    logic [2:0][39:0]    rs;
    logic [2:0][7:0]     ror;

    logic [31:0] z_tab [5];
    logic [7:0]  s_tab [5];

    int n_total;
    int n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [2:0] h1;
        logic [2:0] h2;
        logic [2:0] dsel;

        mac_fp_result_collect_5 #(
            .SIG_WIDTH (23),
            .EXP_WIDTH (8),
            .A_WIDTH   (32),
            .MAC_LAT   (g)
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .start_valid   (sv[g]),
            .start_ready   (sr[g]),
            .mac_select    (sel[g]),
            .mac_z         (mz[g]),
            .mac_status    (ms[g]),
            .res_z         (rz[g]),
            .res_status    (rs[g]),
            .res_status_or (ror[g]),
            .res_valid     (rv[g]),
            .res_ready     (rr[g])
        );

        always @(posedge clk) begin
            h1 <= sel[g];
            h2 <= h1;
        end

        assign dsel  = (g == 0) ? sel[g] : (g == 1) ? h1 : h2;
        assign mz[g] = (dsel < 3'd5) ? z_tab[dsel] : 32'hDEADBEEF;
        assign ms[g] = (dsel < 3'd5) ? s_tab[dsel] : 8'hEE;
    end

    typedef struct {
        int          inst;
        int          exp_lat;
        int          hold;
        logic [31:0] z [5];
        logic [7:0]  s [5];
        logic [159:0] exp_z;
        logic [39:0]  exp_s;
        logic [7:0]   exp_or;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input int i);
        chk("rst_start_ready", 160'(sr[i]), 160'd1);
        chk("rst_mac_select", 160'(sel[i]), 160'd0);
        chk("rst_res_z", rz[i], 160'd0);
        chk("rst_res_status", 160'(rs[i]), 160'd0);
        chk("rst_res_status_or", 160'(ror[i]), 160'd0);
        chk("rst_res_valid", 160'(rv[i]), 160'd0);
    endtask

    task automatic run_sweep(input vec_t v);
        int i;
        int c;
        i = v.inst;
        for (int k = 0; k < 5; k++) begin
            z_tab[k] = v.z[k];
            s_tab[k] = v.s[k];
        end
        chk("idle_start_ready", 160'(sr[i]), 160'd1);
        sv[i] = 1'b1;
        tick();
        sv[i] = 1'b0;
        c = 1;
        chk("start_clear_z", rz[i], 160'd0);
        chk("issue_start_ready", 160'(sr[i]), 160'd0);
        while (!rv[i] && c < 40) begin
            if (c <= 5) chk("issue_select", 160'(sel[i]), 160'(c - 1));
            else        chk("drain_select", 160'(sel[i]), 160'd4);
            tick();
            c++;
        end
        chk("valid_latency", 160'(c), 160'(v.exp_lat));
        chk("res_z", rz[i], v.exp_z);
        chk("res_status", 160'(rs[i]), 160'(v.exp_s));
        chk("res_status_or", 160'(ror[i]), 160'(v.exp_or));
        chk("done_start_ready", 160'(sr[i]), 160'd0);
        for (int h = 0; h < v.hold; h++) begin
            sv[i] = (h == 0);
            tick();
            chk("hold_valid", 160'(rv[i]), 160'd1);
            chk("hold_res_z", rz[i], v.exp_z);
            chk("hold_start_ready", 160'(sr[i]), 160'd0);
        end
        sv[i] = 1'b0;
        rr[i] = 1'b1;
        tick();
        rr[i] = 1'b0;
        chk("after_ready_valid", 160'(rv[i]), 160'd0);
        chk("after_ready_idle", 160'(sr[i]), 160'd1);
        chk("after_ready_select", 160'(sel[i]), 160'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        sv      = '0;
        rr      = '0;
        for (int k = 0; k < 5; k++) begin
            z_tab[k] = '0;
            s_tab[k] = '0;
        end

        vecs[0].inst = 0; vecs[0].exp_lat = 6; vecs[0].hold = 0;
        vecs[0].z = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
        vecs[0].s = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[0].exp_z = 160'h40A00000_40800000_40400000_40000000_3F800000;
        vecs[0].exp_s = 40'h00_00_00_00_00; vecs[0].exp_or = 8'h00;

        vecs[1].inst = 2; vecs[1].exp_lat = 8; vecs[1].hold = 4;
        vecs[1].z = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
        vecs[1].s = '{8'h00, 8'h00, 8'h20, 8'h00, 8'h01};
        vecs[1].exp_z = 160'h40A00000_40800000_40400000_40000000_3F800000;
        vecs[1].exp_s = 40'h01_00_20_00_00; vecs[1].exp_or = 8'h21;

        vecs[2].inst = 1; vecs[2].exp_lat = 7; vecs[2].hold = 0;
        vecs[2].z = '{32'hBF800000, 32'hC0000000, 32'hC0400000, 32'hC0800000, 32'hC0A00000};
        vecs[2].s = '{8'h80, 8'h04, 8'h00, 8'h02, 8'h00};
        vecs[2].exp_z = 160'hC0A00000_C0800000_C0400000_C0000000_BF800000;
        vecs[2].exp_s = 40'h00_02_00_04_80; vecs[2].exp_or = 8'h86;

        vecs[3].inst = 0; vecs[3].exp_lat = 6; vecs[3].hold = 2;
        vecs[3].z = '{32'hBF800000, 32'hC0000000, 32'hC0400000, 32'hC0800000, 32'hC0A00000};
        vecs[3].s = '{8'h00, 8'h10, 8'h00, 8'h00, 8'h08};
        vecs[3].exp_z = 160'hC0A00000_C0800000_C0400000_C0000000_BF800000;
        vecs[3].exp_s = 40'h08_00_00_10_00; vecs[3].exp_or = 8'h18;

        vecs[4].inst = 2; vecs[4].exp_lat = 8; vecs[4].hold = 1;
        vecs[4].z = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
        vecs[4].s = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
        vecs[4].exp_z = 160'h55555555_44444444_33333333_22222222_11111111;
        vecs[4].exp_s = 40'h10_08_04_02_01; vecs[4].exp_or = 8'h1F;

        vecs[5] = vecs[4];
        vecs[5].inst = 0; vecs[5].exp_lat = 6; vecs[5].hold = 0;

        repeat (3) tick();
        for (int i = 0; i < 3; i++) check_reset_vals(i);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) check_reset_vals(i);

        for (int n = 0; n < 4; n++) run_sweep(vecs[n]);

        // Mid-sweep reset on the MAC_LAT=0 and MAC_LAT=2 collectors together.
        for (int k = 0; k < 5; k++) begin
            z_tab[k] = vecs[0].z[k];
            s_tab[k] = 8'hFF;
        end
        sv[0] = 1'b1;
        sv[2] = 1'b1;
        tick();
        sv = '0;
        tick();
        tick();
        chk("pre_reset_lane0", 160'(rz[0][31:0]), 160'h3F800000);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset_vals(0);
        check_reset_vals(2);
        run_sweep(vecs[4]);
        run_sweep(vecs[5]);

        // Back-to-back sweeps on the MAC_LAT=1 collector.
        for (int k = 0; k < 5; k++) begin
            z_tab[k] = vecs[0].z[k];
            s_tab[k] = 8'h00;
        end
        sv[1] = 1'b1;
        rr[1] = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            chk("b2b_valid", 160'(rv[1]), 160'((c % 8) == 7));
            if ((c % 8) == 1) chk("b2b_clear_z", rz[1], 160'd0);
            if ((c % 8) == 7) chk("b2b_res_z", rz[1], vecs[0].exp_z);
        end
        sv[1] = 1'b0;
        repeat (4) tick();
        rr[1] = 1'b0;
        chk("b2b_final_idle", 160'(sr[1]), 160'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mac_fp_result_collect_5.md
# mac_fp_result_collect_5

Sequencer and result collector for the 5-input FP MAC operand mux. On a start handshake it drives the MAC's `select` through lanes 0..4, one per cycle. It captures each lane's `z`/`status` after the MAC latency and packs all five results into one bus. It presents that bus with a valid/ready handshake.

## Interface
- `SIG_WIDTH`, default 23: significand width.
- `EXP_WIDTH`, default 8: exponent width.
- `A_WIDTH`, default SIG_WIDTH+EXP_WIDTH+1: one FP word.
- `MAC_LAT`, default 0: cycles from `mac_select` change to matching `mac_z`/`mac_status`. Legal range 0..3.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `start_valid`  in  1  request to run one 5-lane sweep.
- `start_ready`  out  1  high only in IDLE.
- `mac_select`  out  3  lane index to MAC mux, registered.
- `mac_z`  in  A_WIDTH  MAC result.
- `mac_status`  in  8  MAC status flags.
- `res_z`  out  5*A_WIDTH  packed results; lane k at `[k*A_WIDTH +: A_WIDTH]`.
- `res_status`  out  40  packed status; lane k at `[k*8 +: 8]`.
- `res_status_or`  out  8  bitwise OR of the five status bytes.
- `res_valid`  out  1  result bus valid.
- `res_ready`  in  1  consumer accepts result.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: `start_ready`=1 and `mac_select`=0. On `start_valid`, go to ISSUE, clear `res_z`/`res_status`/`res_status_or` to 0, and set the lane counter to 0.
- ISSUE: `mac_select` = lane counter, stepping 0,1,2,3,4 on consecutive cycles. After lane 4, go to DRAIN if MAC_LAT>0, else DONE. Select values 5..7 are never driven.
- Tag pipe: each issued lane enters a delay line as {valid, lane}, MAC_LAT stages deep (pass-through when MAC_LAT=0). When a tag emerges valid, `mac_z`/`mac_status` are written into that lane's slot and OR-ed into `res_status_or`.
- DRAIN: `mac_select` holds 4. Exit to DONE on the cycle lane 4's capture is registered.
- DONE: `res_valid`=1 and the result buses are stable. On `res_ready`, go to IDLE. `start_valid` is ignored in DONE; there is no direct DONE->ISSUE path.
- `start_valid` is ignored in ISSUE, DRAIN and DONE.
- Reset, including mid-sweep: state=IDLE, tag pipe invalidated, in-flight lanes discarded.

## Timing
- Reset values: `start_ready`=1, `mac_select`=0, `res_z`=0, `res_status`=0, `res_status_or`=0, `res_valid`=0.
- Start accepted at edge ending cycle T. `mac_select`=k during cycle T+1+k.
- Lane k captured at edge ending cycle T+1+k+MAC_LAT.
- `res_valid` first high in cycle T+6+MAC_LAT.
- With `res_ready` tied high and `start_valid` held high, sweeps repeat every 7+MAC_LAT cycles.
- Result buses change only during ISSUE/DRAIN captures and at start clear; they never change while `res_valid`=1.

## Structure
- Package `mac_fp_pkg` holds:
  - width constants (SIG/EXP/A widths);
  - `LANES`=5 and `LANE_W`=3;
  - the FSM state enum, shared with the mux block.
- Sub-module `mac_tag_pipe`: parameterised delay line of {valid, lane[2:0]}, depth MAC_LAT, with synchronous active-low clear.

## Test plan
- MAC_LAT=0, MAC model returns per-lane z 32'h3F800000, 40000000, 40400000, 40800000, 40A00000 -> `res_z` packs lane0 in the LSBs, `res_valid` high exactly at T+6, `mac_select` sequence 0..4.
- MAC_LAT=2, same model delayed 2 cycles -> identical `res_z`, `res_valid` at T+8, `mac_select` held at 4 for 2 DRAIN cycles.
- `res_ready` low for 4 cycles in DONE -> `res_valid` and `res_z` stable, `start_ready`=0, a `start_valid` pulse is ignored; the next `res_ready` returns the FSM to IDLE.
- Status: lane2 status 8'h20, lane4 status 8'h01, others 0 -> `res_status_or`=8'h21, `res_status[23:16]`=8'h20, `res_status[39:32]`=8'h01.
- `rst_n` low during cycle T+3 -> next cycle IDLE with all outputs at reset values. The following sweep produces correct data with no stale lane captures.
- `start_valid` held high, `res_ready` tied 1, MAC_LAT=1 -> back-to-back sweeps with `res_valid` pulses every 8 cycles, and `res_z` cleared at each start.
